// File: rtl/cla_pipe_adder_if.sv
`default_nettype none
// ============================================================================
// Module      : cla_pipe_adder_if
// Description : Operand/result valid-ready bundle for cla_pipe_adder.
// Revision    : 1.0 - initial release
// ============================================================================
interface cla_pipe_adder_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             c_in;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             c_out;
    logic             ovf;

    modport master (
        output in_valid, a, b, c_in, sub, out_ready,
        input  in_ready, out_valid, sum, c_out, ovf
    );

    modport slave (
        input  in_valid, a, b, c_in, sub, out_ready,
        output in_ready, out_valid, sum, c_out, ovf
    );
endinterface
`default_nettype wire

// File: rtl/cla_pipe_adder.sv
`default_nettype none
// ============================================================================
// Module      : cla_pipe_adder
// Description : Pipelined carry-lookahead adder/subtractor, one GROUP-bit
//               lookahead group resolved per stage. CLA_PIPE_SAT_EN enables
//               signed saturation of the result.
// Revision    : 1.0 - initial release
// ============================================================================
module cla_pipe_adder #(
    parameter int WIDTH = 16,
    parameter int GROUP = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    cla_pipe_adder_if.slave bus
);
    localparam int NG = WIDTH / GROUP;
    localparam logic [WIDTH-1:0] C_SAT_POS = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] C_SAT_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    // Level k holds operands not yet consumed; level k+1 holds sum groups 0..k.
    logic [NG:0]      r_vld;
    logic [WIDTH-1:0] r_a   [0:NG-1];
    logic [WIDTH-1:0] r_b   [0:NG-1];
    logic [NG-1:0]    r_cy;
    logic [WIDTH-1:0] r_sum [1:NG];
    logic             r_c_out;
    logic             r_ovf;

    logic             w_en;
    logic             w_accept;
    logic [WIDTH-1:0] w_sum_nxt [0:NG-1];
    logic [NG-1:0]    w_cy_nxt;
    logic             w_c_msb;
    logic             w_ovf;
    logic [WIDTH-1:0] w_sum_fin;

    // Sum-of-products lookahead: c[i+1] = G[i:0] | P[i:0] & cin.
    function automatic logic [GROUP:0] cla_carries(
        input logic [GROUP-1:0] p,
        input logic [GROUP-1:0] g,
        input logic             cin
    );
        logic [GROUP:0] c;
        logic           acc_g;
        logic           acc_p;
        c[0] = cin;
        for (int i = 0; i < GROUP; i++) begin
            acc_g = 1'b0;
            acc_p = 1'b1;
            for (int j = i; j >= 0; j--) begin
                acc_g = acc_g | (acc_p & g[j]);
                acc_p = acc_p & p[j];
            end
            c[i+1] = acc_g | (acc_p & cin);
        end
        return c;
    endfunction

    assign w_en         = !r_vld[NG] || bus.out_ready;
    assign w_accept     = bus.in_valid && w_en;
    assign bus.in_ready = w_en;

    for (genvar k = 0; k < NG; k++) begin : g_stage
        logic [GROUP-1:0] w_p;
        logic [GROUP-1:0] w_g;
        logic [GROUP-1:0] w_s;
        logic [GROUP:0]   w_c;
        logic [WIDTH-1:0] w_base;
        logic [WIDTH-1:0] w_merged;

        assign w_p         = r_a[k][k*GROUP +: GROUP] ^ r_b[k][k*GROUP +: GROUP];
        assign w_g         = r_a[k][k*GROUP +: GROUP] & r_b[k][k*GROUP +: GROUP];
        assign w_c         = cla_carries(w_p, w_g, r_cy[k]);
        assign w_s         = w_p ^ w_c[GROUP-1:0];
        assign w_cy_nxt[k] = w_c[GROUP];

        if (k == 0) begin : g_first
            assign w_base = '0;
        end else begin : g_rest
            assign w_base = r_sum[k];
        end

        always_comb begin
            w_merged                    = w_base;
            w_merged[k*GROUP +: GROUP]  = w_s;
        end
        assign w_sum_nxt[k] = w_merged;

        if (k == NG - 1) begin : g_msb
            assign w_c_msb = w_c[GROUP-1];
        end
    end

    assign w_ovf = w_c_msb ^ w_cy_nxt[NG-1];

`ifdef CLA_PIPE_SAT_EN
    // Both operands share a's sign whenever overflow is possible.
    assign w_sum_fin = w_ovf ? (r_a[NG-1][WIDTH-1] ? C_SAT_NEG : C_SAT_POS)
                             : w_sum_nxt[NG-1];
`else
    assign w_sum_fin = w_sum_nxt[NG-1];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld   <= '0;
            r_cy    <= '0;
            r_c_out <= 1'b0;
            r_ovf   <= 1'b0;
            for (int k = 0; k < NG; k++) begin
                r_a[k]     <= '0;
                r_b[k]     <= '0;
                r_sum[k+1] <= '0;
            end
        end else if (w_en) begin
            r_vld[0] <= w_accept;
            r_a[0]   <= bus.a;
            r_b[0]   <= bus.sub ? ~bus.b : bus.b;
            r_cy[0]  <= bus.sub ^ bus.c_in;
            for (int k = 0; k < NG - 1; k++) begin
                r_vld[k+1] <= r_vld[k];
                r_a[k+1]   <= r_a[k];
                r_b[k+1]   <= r_b[k];
                r_cy[k+1]  <= w_cy_nxt[k];
                r_sum[k+1] <= w_sum_nxt[k];
            end
            r_vld[NG] <= r_vld[NG-1];
            r_sum[NG] <= w_sum_fin;
            r_c_out   <= w_cy_nxt[NG-1];
            r_ovf     <= w_ovf;
        end
    end

    assign bus.out_valid = r_vld[NG];
    assign bus.sum       = r_sum[NG];
    assign bus.c_out     = r_c_out;
    assign bus.ovf       = r_ovf;
endmodule
`default_nettype wire

// File: tb/tb_cla_pipe_adder.sv
`default_nettype none
// ============================================================================
// Module      : tb_cla_pipe_adder
// Description : Self-checking bench for cla_pipe_adder (directed + random vs
//               arithmetic reference model; honours CLA_PIPE_SAT_EN).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cla_pipe_adder;
    localparam int WIDTH = 16;
    localparam int GROUP = 4;
    localparam int NG    = WIDTH / GROUP;
`ifdef CLA_PIPE_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    typedef struct packed {
        logic [WIDTH-1:0] sum;
        logic             c_out;
        logic             ovf;
    } res_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    cla_pipe_adder_if #(.WIDTH(WIDTH)) bus ();

    cla_pipe_adder #(.WIDTH(WIDTH), .GROUP(GROUP)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    res_t exp_q[$];
    res_t exp_head;
    res_t prev_out;
    logic prev_stall = 1'b0;
    int   n_checks   = 0;
    int   n_errors   = 0;
    int   n_out      = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the effective operands.
    function automatic res_t ref_model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                       input logic c_in, input logic sub);
        logic [WIDTH-1:0] beff;
        logic [WIDTH:0]   full;
        res_t             r;
        beff    = sub ? ~b : b;
        full    = {1'b0, a} + {1'b0, beff} + {{WIDTH{1'b0}}, (sub ? ~c_in : c_in)};
        r.sum   = full[WIDTH-1:0];
        r.c_out = full[WIDTH];
        r.ovf   = (a[WIDTH-1] == beff[WIDTH-1]) && (r.sum[WIDTH-1] != a[WIDTH-1]);
        if (SAT && r.ovf)
            r.sum = a[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        return r;
    endfunction

    // Scoreboard / protocol monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            prev_stall = 1'b0;
        end else begin
            check_eq("in_ready", 32'(bus.in_ready), 32'(!bus.out_valid || bus.out_ready));
            if (prev_stall) begin
                check_eq("hold_valid", 32'(bus.out_valid), 32'd1);
                check_eq("hold_data", 32'({bus.sum, bus.c_out, bus.ovf}), 32'(prev_out));
            end
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    check_eq("unexpected_out", 32'(bus.out_valid), 32'd0);
                end else begin
                    exp_head = exp_q.pop_front();
                    n_out++;
                    check_eq("sum", 32'(bus.sum), 32'(exp_head.sum));
                    check_eq("c_out", 32'(bus.c_out), 32'(exp_head.c_out));
                    check_eq("ovf", 32'(bus.ovf), 32'(exp_head.ovf));
                end
            end
            if (bus.in_valid && bus.in_ready)
                exp_q.push_back(ref_model(bus.a, bus.b, bus.c_in, bus.sub));
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_out   = {bus.sum, bus.c_out, bus.ovf};
        end
    end

    task automatic drive_beat(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                              input logic c_in, input logic sub);
        bus.a    = a;
        bus.b    = b;
        bus.c_in = c_in;
        bus.sub  = sub;
    endtask

    task automatic directed(input string tag, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                            input logic c_in, input logic sub,
                            input logic [WIDTH-1:0] e_sum, input logic e_cout, input logic e_ovf);
        int lat;
        @(posedge clk); #1;
        drive_beat(a, b, c_in, sub);
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        lat = 0;
        while (!bus.out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check_eq({tag, "_latency"}, 32'(lat), 32'(NG));
        check_eq({tag, "_sum"}, 32'(bus.sum), 32'(e_sum));
        check_eq({tag, "_c_out"}, 32'(bus.c_out), 32'(e_cout));
        check_eq({tag, "_ovf"}, 32'(bus.ovf), 32'(e_ovf));
        @(posedge clk); #1;
        check_eq({tag, "_pulse"}, 32'(bus.out_valid), 32'd0);
    endtask

    task automatic backpressure();
        logic [WIDTH-1:0] va [6];
        logic [WIDTH-1:0] vb [6];
        int   idx;
        int   out0;
        logic fire;
        idx  = 0;
        out0 = n_out;
        for (int i = 0; i < 6; i++) begin
            va[i] = WIDTH'($urandom);
            vb[i] = WIDTH'($urandom);
        end
        for (int cyc = 0; cyc < 40; cyc++) begin
            bus.in_valid  = (idx < 6);
            if (idx < 6) drive_beat(va[idx], vb[idx], idx[0], idx[1]);
            bus.out_ready = !(cyc >= 5 && cyc <= 8);
            @(negedge clk);
            fire = bus.in_valid && bus.in_ready;
            if (cyc >= 5 && cyc <= 8) check_eq("bp_in_ready_low", 32'(bus.in_ready), 32'd0);
            @(posedge clk); #1;
            if (fire) idx++;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        check_eq("bp_results", 32'(n_out - out0), 32'd6);
        check_eq("bp_queue_empty", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic reset_tests();
        int seen;
        int guard;
        // Mid-flight reset before any result emerges.
        for (int cyc = 0; cyc < 3; cyc++) begin
            drive_beat(WIDTH'($urandom) | 16'h0101, WIDTH'($urandom), 1'b1, 1'b0);
            bus.in_valid = 1'b1;
            if (cyc == 2) begin
                #3 rst_n = 1'b0;
                #1;
                check_eq("rst_out_valid", 32'(bus.out_valid), 32'd0);
                check_eq("rst_sum", 32'(bus.sum), 32'd0);
                check_eq("rst_in_ready", 32'(bus.in_ready), 32'd1);
            end
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (bus.out_valid) seen++;
        end
        check_eq("no_stale_after_rst", 32'(seen), 32'd0);

        // Reset while a nonzero result is being held.
        bus.out_ready = 1'b0;
        drive_beat(16'hFFFF, 16'h8000, 1'b0, 1'b0);
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        guard = 0;
        while (!bus.out_valid && guard < 20) begin
            @(posedge clk); #1;
            guard++;
        end
        check_eq("held_sum", 32'(bus.sum), SAT ? 32'h8000 : 32'h7FFF);
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        check_eq("rst2_out_valid", 32'(bus.out_valid), 32'd0);
        check_eq("rst2_sum", 32'(bus.sum), 32'd0);
        check_eq("rst2_c_out", 32'(bus.c_out), 32'd0);
        check_eq("rst2_ovf", 32'(bus.ovf), 32'd0);
        check_eq("rst2_in_ready", 32'(bus.in_ready), 32'd1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
    endtask

    task automatic random_run(input int beats);
        int   sent;
        int   guard;
        logic pend;
        logic fire;
        sent = 0;
        pend = 1'b0;
        while (sent < beats) begin
            if (!pend && $urandom_range(3) != 0) begin
                pend = 1'b1;
                drive_beat(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), 1'($urandom));
            end
            bus.in_valid  = pend;
            bus.out_ready = ($urandom_range(3) != 0);
            @(negedge clk);
            fire = bus.in_valid && bus.in_ready;
            @(posedge clk); #1;
            if (fire) begin
                pend = 1'b0;
                sent++;
            end
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        guard = 0;
        while (exp_q.size() != 0 && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        check_eq("drain_empty", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        drive_beat('0, '0, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check_eq("reset_out_valid", 32'(bus.out_valid), 32'd0);
        check_eq("reset_sum", 32'(bus.sum), 32'd0);
        check_eq("reset_c_out", 32'(bus.c_out), 32'd0);
        check_eq("reset_ovf", 32'(bus.ovf), 32'd0);
        check_eq("reset_in_ready", 32'(bus.in_ready), 32'd1);
        @(posedge clk); #1;
        rst_n = 1'b1;

        directed("add_wrap", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        directed("sub_ovf", 16'h8000, 16'h0001, 1'b0, 1'b1,
                 SAT ? 16'h8000 : 16'h7FFF, 1'b1, 1'b1);
        directed("add_ovf", 16'h7FFF, 16'h0000, 1'b1, 1'b0,
                 SAT ? 16'h7FFF : 16'h8000, 1'b0, 1'b1);
        directed("sub_borrow", 16'h0000, 16'h0000, 1'b1, 1'b1, 16'hFFFF, 1'b0, 1'b0);

        backpressure();
        reset_tests();
        random_run(10000);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire
